serial_subtractor: RTL

- Bit-serial, two's-complement signed subtractor computing output_y = input_a - input_b, LSB first, one bit per clock.
- Pairs with the combinational simple_adder. Shares its operand, result and overflow conventions, but performs the inverse operation sequentially under a start/done handshake.
- Used where area matters more than latency; results are checkable against the same exhaustive signed reference model used for the adder.

---
 rtl/serial_subtractor.sv | 72 +++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial signed a-b, LSB first, with start/done handshake.
// Optional SERIAL_SUBTRACTOR_SATURATE_EN clamps output_y on signed overflow.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] output_y,
  output logic             overflow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, nb_r, res, res_nx, y_nx;
  logic [CW-1:0] cnt;
  logic carry, s, cout, last, accept, ovf_nx;
  always_comb begin
    s = a_r[0] ^ nb_r[0] ^ carry;
    cout = (a_r[0] & nb_r[0]) | (a_r[0] & carry) | (nb_r[0] & carry);
    last = cnt == CW'(WIDTH - 1);
    accept = start && state != SHIFT;
    state_nx = (state == SHIFT) ? (last ? DONE : SHIFT) : (accept ? SHIFT : IDLE);
    res_nx = {s, res[WIDTH-1:1]};
    ovf_nx = carry ^ cout;
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
    // on the last step a_r[0] holds the minuend sign bit
    y_nx = ovf_nx ? {a_r[0], {(WIDTH-1){~a_r[0]}}} : res_nx;
`else
    y_nx = res_nx;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      output_y <= '0;
      overflow <= 1'b0;
      a_r <= '0;
      nb_r <= '0;
      res <= '0;
      carry <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      busy <= state_nx == SHIFT;
      done <= state_nx == DONE;
      if (accept) begin
        a_r <= input_a;
        nb_r <= ~input_b;
        carry <= 1'b1;
        cnt <= '0;
        res <= '0;
      end else if (state == SHIFT) begin
        a_r <= a_r >> 1;
        nb_r <= nb_r >> 1;
        carry <= cout;
        cnt <= cnt + 1'b1;
        res <= res_nx;
        if (last) begin
          output_y <= y_nx;
          overflow <= ovf_nx;
        end
      end
    end
  end
endmodule
